// File: rtl/move_undo_stack.sv
// LIFO of cube move codes, replayed inverted on undo; outputs are registered, first beat the cycle after undo_start.
// Replay beats hold while out_ready is low; pushes are dropped (err set) when full or the face code is invalid.
module move_undo_stack #(
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push_valid,
   input  logic [3:0]               push_move,
   input  logic                     undo_start,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [3:0]               out_move,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REPLAY = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [3:0]      out_move_q, out_move_d;
   logic            err_q, err_d;
   logic            push_ok;
   logic            face_ok;
   logic            full_w;
   logic [AW-1:0]   top_idx;
   logic [AW-1:0]   next_idx;
   logic [3:0]      mem_q [DEPTH];

   assign face_ok  = (push_move[2:0] <= 3'd5);
   assign full_w   = (count_q == CW'(DEPTH));
   assign top_idx  = AW'(count_q - CW'(1));
   assign next_idx = AW'(count_q - CW'(2));

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      out_move_d = out_move_q;
      err_d      = err_q;
      push_ok    = 1'b0;
      if (clear) begin
         state_d    = IDLE;
         count_d    = '0;
         out_move_d = '0;
         err_d      = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (push_valid) begin
                  if (!face_ok || full_w) begin
                     err_d = 1'b1;
                  end else begin
                     push_ok = 1'b1;
                     count_d = count_q + CW'(1);
                  end
               end
               // A same-cycle push becomes the top of stack, so it is replayed first.
               if (undo_start) begin
                  if (push_ok) begin
                     state_d    = REPLAY;
                     out_move_d = {~push_move[3], push_move[2:0]};
                  end else if (count_q != '0) begin
                     state_d    = REPLAY;
                     out_move_d = {~mem_q[top_idx][3], mem_q[top_idx][2:0]};
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            REPLAY: begin
               if (out_ready) begin
                  count_d = count_q - CW'(1);
                  if (count_q == CW'(1)) begin
                     state_d    = DONE;
                     out_move_d = '0;
                  end else begin
                     out_move_d = {~mem_q[next_idx][3], mem_q[next_idx][2:0]};
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         out_move_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         out_move_q <= out_move_d;
         err_q      <= err_d;
      end
   end

   // Storage needs no reset: only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[count_q[AW-1:0]] <= push_move;
      end
   end

   assign out_valid = (state_q == REPLAY);
   assign out_move  = out_move_q;
   assign count     = count_q;
   assign full      = full_w;
   assign empty     = (count_q == '0);
   assign busy      = (state_q == REPLAY);
   assign done      = (state_q == DONE);
   assign err       = err_q;

endmodule

// File: doc/move_undo_stack.md
MOVE_UNDO_STACK -- requirements
Module: move_undo_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning the maximum number of stored move codes (power of two, 2..64).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port clear, input, 1, meaning a synchronous flush of all state.
REQ-005 The block SHALL have port push_valid, input, 1, meaning push_move is offered this cycle.
REQ-006 The block SHALL have port push_move, input, 4, meaning a move code: bits [2:0] are the face (0..5), and bit 3 is the direction (0 = clockwise, 1 = counter-clockwise).
REQ-007 The block SHALL have port undo_start, input, 1, meaning a request to replay the stored moves inverted in LIFO order.
REQ-008 The block SHALL have port out_ready, input, 1, meaning the downstream consumer accepts out_move this cycle.
REQ-009 The block SHALL have port out_valid, output, 1, meaning out_move holds a valid inverse move.
REQ-010 The block SHALL have port out_move, output, 4, meaning the inverse move code.
REQ-011 The block SHALL have port count, output, clog2(DEPTH)+1, meaning the number of stored moves.
REQ-012 The block SHALL have ports full, empty, busy, done and err, all outputs of width 1, meaning respectively: count==DEPTH; count==0; state is REPLAY; a one-cycle replay-complete pulse; and a sticky error flag.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, REPLAY and DONE.
REQ-014 In IDLE, a push SHALL be accepted when push_valid=1, push_move[2:0]<=5 and full=0: the move is stored at index count and count increments on the same edge.
REQ-015 A push with push_move[2:0] of 6 or 7 SHALL be dropped and SHALL set err.
REQ-016 A push while full=1 SHALL be dropped and SHALL set err; count SHALL remain DEPTH.
REQ-017 In IDLE, undo_start=1 with count>0 SHALL move the FSM to REPLAY, and out_valid SHALL be 1 on the following cycle.
REQ-018 In IDLE, undo_start=1 with count==0 SHALL move the FSM to DONE with no out_valid beat.
REQ-019 When push and undo_start are asserted in the same IDLE cycle, the push SHALL be accepted first, and the replay SHALL include that move as its first output.
REQ-020 In REPLAY, out_move SHALL equal {~mem[count-1][3], mem[count-1][2:0]}, i.e. the same face with the opposite direction.
REQ-021 While out_valid=1 and out_ready=0, out_move and count SHALL be held stable.
REQ-022 A beat with out_valid=1 and out_ready=1 SHALL decrement count; the next entry SHALL be presented on the next cycle with no bubble.
REQ-023 The beat that brings count to 0 SHALL move the FSM to DONE, and out_valid SHALL be 0 on the next cycle.
REQ-024 DONE SHALL last exactly one cycle with done=1, and SHALL then return to IDLE.
REQ-025 push_valid in REPLAY or DONE SHALL be ignored without setting err.
REQ-026 undo_start outside IDLE SHALL be ignored.
REQ-027 clear=1 SHALL take priority over every other input: on the next edge count=0, FSM=IDLE, out_valid=0, done=0 and err=0; a replay in progress SHALL be abandoned.
REQ-028 err SHALL remain 1 until clear or reset.
REQ-029 All outputs SHALL be registered, or decoded only from registered state, with no combinational path from any input to any output.
REQ-030 The storage array SHALL require no reset; only valid entries, those below count, are ever observable.

Reset
REQ-031 When reset=0, the block SHALL asynchronously force FSM=IDLE, count=0, out_valid=0, out_move=0, done=0 and err=0, so that empty=1, full=0 and busy=0.
REQ-032 Reset asserted mid-replay SHALL abandon the replay immediately; out_valid=0 SHALL be visible before the next clock edge.
REQ-033 After reset deasserts, the first push SHALL be accepted on the first rising edge at which reset=1.

Verification
REQ-034 The bench SHALL check this scenario: push 0x2, 0xB, 0x5; then undo_start with out_ready=1 -> out_move sequence 0xD, 0x3, 0xA on consecutive cycles, then done=1 for one cycle, count=0.
REQ-035 The bench SHALL check this scenario: DEPTH=4, push 5 valid moves -> count=4, full=1, err=1; replay emits 4 beats, and the 5th move is absent.
REQ-036 The bench SHALL check this scenario: push 0x6 -> count unchanged, err=1; then clear -> err=0, count=0.
REQ-037 The bench SHALL check this scenario: replay 3 moves with out_ready toggling 1,0,0,1,1 -> out_move held during stalls, exactly 3 accepted beats, in order.
REQ-038 The bench SHALL check this scenario: reset=0 during the second replay beat -> out_valid=0 asynchronously; after release, empty=1 and busy=0.
REQ-039 The bench SHALL check this scenario: undo_start with empty=1 -> no out_valid; done=1 one cycle later; push 0x1 together with undo_start -> single beat 0x9.
